ram_arbiter: RTL and testbench

- Shares the single RAM port between CPUS caches, each with one instruction and one data channel.
- Round-robin arbitration between CPUs; within a CPU, data has priority over instruction.
- One word-sized access is granted at a time and held until RAM reports ACCESS.
- Sits between the per-CPU cache interfaces and the RAM model; replaces single-requester memory sequencing in multicore builds.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/rr_picker.sv | 18 +
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/RAM types for the memory subsystem
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, XFER} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate-priority pick of the first set request at or after ptr
module rr_picker #(
  parameter int CPUS = 2,
  parameter int IW = CPUS > 1 ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);
  // Scan offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    idx = '0;
    valid = |req;
    for (int i = CPUS - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % CPUS]) idx = IW'((int'(ptr) + i) % CPUS);
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin share of one RAM port among per-CPU i/d channels
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  ramstate_t                ramstate
);
  localparam int IW = CPUS > 1 ? $clog2(CPUS) : 1;
  arb_state_t state_q, state_d;
  logic [IW-1:0] grant_cpu_q, grant_cpu_d, rr_ptr_q, rr_ptr_d, win;
  logic grant_is_d_q, grant_is_d_d, grant_is_wr_q, grant_is_wr_d;
  logic win_valid, live, drive, done;
  logic [WORD_W-1:0] g_iaddr, g_daddr, g_dstore;
  rr_picker #(.CPUS(CPUS)) u_pick (
    .req  (iREN | dREN | dWEN),
    .ptr  (rr_ptr_q),
    .idx  (win),
    .valid(win_valid)
  );
  // Drive the RAM and the requester handshakes from the registered grant
  always_comb begin
    g_iaddr = iaddr[int'(grant_cpu_q)*WORD_W +: WORD_W];
    g_daddr = daddr[int'(grant_cpu_q)*WORD_W +: WORD_W];
    g_dstore = dstore[int'(grant_cpu_q)*WORD_W +: WORD_W];
    live = grant_is_d_q ? (grant_is_wr_q ? dWEN[grant_cpu_q] : dREN[grant_cpu_q]) : iREN[grant_cpu_q];
    drive = state_q == XFER && live;
    done = drive && ramstate == ACCESS;
    ramREN = drive && !grant_is_wr_q;
    ramWEN = drive && grant_is_wr_q;
    ramaddr = drive ? (grant_is_d_q ? g_daddr : g_iaddr) : '0;
    ramstore = drive && grant_is_wr_q ? g_dstore : '0;
    iwait = iREN;
    dwait = dREN | dWEN;
    iload = '0;
    dload = '0;
    if (done && grant_is_d_q) dwait[grant_cpu_q] = 1'b0;
    if (done && !grant_is_d_q) iwait[grant_cpu_q] = 1'b0;
    if (done && grant_is_d_q && !grant_is_wr_q) dload[int'(grant_cpu_q)*WORD_W +: WORD_W] = ramload;
    if (done && !grant_is_d_q) iload[int'(grant_cpu_q)*WORD_W +: WORD_W] = ramload;
  end
  // Grant in IDLE; leave XFER on completion or when the requester withdraws
  always_comb begin
    state_d = state_q;
    grant_cpu_d = grant_cpu_q;
    grant_is_d_d = grant_is_d_q;
    grant_is_wr_d = grant_is_wr_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && win_valid) begin
      state_d = XFER;
      grant_cpu_d = win;
      grant_is_d_d = dREN[win] | dWEN[win];
      grant_is_wr_d = dWEN[win];
    end
    if (state_q == XFER && (!live || ramstate == ACCESS)) state_d = IDLE;
    if (done) rr_ptr_d = grant_cpu_q == IW'(CPUS - 1) ? '0 : grant_cpu_q + 1'b1;
  end
  // Arbiter state; async reset drops any grant so RAM enables fall at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_cpu_q <= '0;
      grant_is_d_q <= 1'b0;
      grant_is_wr_q <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_cpu_q <= grant_cpu_d;
      grant_is_d_q <= grant_is_d_d;
      grant_is_wr_q <= grant_is_wr_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus reset-mid-transfer sequence
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] iREN = '0, dREN = '0, dWEN = '0;
  logic [63:0] iaddr = {32'h140, 32'h40};
  logic [63:0] daddr = {32'h80, 32'h100};
  logic [63:0] dstore = {32'h12345678, 32'hAAAA5555};
  logic [1:0] iwait, dwait;
  logic [63:0] iload, dload;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload = '0;
  ramstate_t ramstate = FREE;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic [1:0] ir, dr, dw;
    ramstate_t rs;
    logic [31:0] rl;
    logic ren, wen;
    logic [31:0] addr, st;
    logic [1:0] iw, dwt;
    logic [63:0] il, dl;
  } vec_t;
  vec_t tv[$];

  ram_arbiter #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic void add(logic [1:0] ir, dr, dw, ramstate_t rs, logic [31:0] rl,
                              logic ren, wen, logic [31:0] addr, st, logic [1:0] iw, dwt,
                              logic [63:0] il, dl);
    tv.push_back('{ir, dr, dw, rs, rl, ren, wen, addr, st, iw, dwt, il, dl});
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //  ir dr dw  rs      rl            ren wen addr     store          iw dw  iload           dload
    add(1, 0, 0, FREE,   0,             0, 0, 0,       0,             1, 0,  0,              0);
    add(1, 0, 0, BUSY,   0,             1, 0, 'h40,    0,             1, 0,  0,              0);
    add(1, 0, 0, BUSY,   0,             1, 0, 'h40,    0,             1, 0,  0,              0);
    add(1, 0, 0, ACCESS, 'hDEADBEEF,    1, 0, 'h40,    0,             0, 0,  'hDEADBEEF,     0);
    add(0, 0, 0, FREE,   0,             0, 0, 0,       0,             0, 0,  0,              0);
    add(0, 0, 2, FREE,   0,             0, 0, 0,       0,             0, 2,  0,              0);
    add(0, 0, 2, BUSY,   0,             0, 1, 'h80,    'h12345678,    0, 2,  0,              0);
    add(0, 0, 2, ERROR,  0,             0, 1, 'h80,    'h12345678,    0, 2,  0,              0);
    add(0, 0, 2, ACCESS, 'hFFFFFFFF,    0, 1, 'h80,    'h12345678,    0, 0,  0,              0);
    add(0, 0, 0, FREE,   0,             0, 0, 0,       0,             0, 0,  0,              0);
    add(0, 3, 0, FREE,   0,             0, 0, 0,       0,             0, 3,  0,              0);
    add(0, 3, 0, ACCESS, 'h11,          1, 0, 'h100,   0,             0, 2,  0,              'h11);
    add(0, 3, 0, FREE,   0,             0, 0, 0,       0,             0, 3,  0,              0);
    add(0, 3, 0, ACCESS, 'h22,          1, 0, 'h80,    0,             0, 1,  0,              64'h22_00000000);
    add(0, 3, 0, FREE,   0,             0, 0, 0,       0,             0, 3,  0,              0);
    add(0, 3, 0, ACCESS, 'h33,          1, 0, 'h100,   0,             0, 2,  0,              'h33);
    add(0, 0, 0, FREE,   0,             0, 0, 0,       0,             0, 0,  0,              0);
    add(1, 1, 0, FREE,   0,             0, 0, 0,       0,             1, 1,  0,              0);
    add(1, 1, 0, ACCESS, 'h44,          1, 0, 'h100,   0,             1, 0,  0,              'h44);
    add(1, 0, 0, FREE,   0,             0, 0, 0,       0,             1, 0,  0,              0);
    add(1, 0, 0, ACCESS, 'h55,          1, 0, 'h40,    0,             0, 0,  'h55,           0);
    add(0, 0, 0, FREE,   0,             0, 0, 0,       0,             0, 0,  0,              0);
    add(0, 1, 0, FREE,   0,             0, 0, 0,       0,             0, 1,  0,              0);
    add(0, 1, 0, BUSY,   0,             1, 0, 'h100,   0,             0, 1,  0,              0);
    add(0, 0, 0, BUSY,   0,             0, 0, 0,       0,             0, 0,  0,              0);
    add(3, 0, 0, FREE,   0,             0, 0, 0,       0,             3, 0,  0,              0);
    add(3, 0, 0, ACCESS, 'h66,          1, 0, 'h140,   0,             1, 0,  64'h66_00000000, 0);
    add(1, 0, 0, FREE,   0,             0, 0, 0,       0,             1, 0,  0,              0);
    add(1, 0, 0, ACCESS, 'h77,          1, 0, 'h40,    0,             0, 0,  'h77,           0);
    add(0, 0, 0, FREE,   0,             0, 0, 0,       0,             0, 0,  0,              0);

    iREN = 2'b01; dREN = 2'b10;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ctrl", {ramREN, ramWEN, iwait, dwait, ramaddr, ramstore}, {1'b0, 1'b0, 2'b01, 2'b10, 64'h0});
    chk("reset_load", {iload, dload}, 128'h0);
    iREN = '0; dREN = '0;
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    foreach (tv[k]) begin
      iREN = tv[k].ir; dREN = tv[k].dr; dWEN = tv[k].dw;
      ramstate = tv[k].rs; ramload = tv[k].rl;
      @(negedge CLK);
      chk($sformatf("vec%0d_ctrl", k), {ramREN, ramWEN, iwait, dwait, ramaddr, ramstore},
          {tv[k].ren, tv[k].wen, tv[k].iw, tv[k].dwt, tv[k].addr, tv[k].st});
      chk($sformatf("vec%0d_load", k), {iload, dload}, {tv[k].il, tv[k].dl});
      @(posedge CLK); #1;
    end

    dREN = 2'b01; ramstate = FREE;
    @(posedge CLK); #1;
    ramstate = BUSY;
    @(negedge CLK);
    chk("rst_xfer_pre", {ramREN, ramaddr}, {1'b1, 32'h100});
    #1 RST = 1'b1;
    #1 chk("rst_xfer_async", {ramREN, ramWEN, ramaddr}, {1'b0, 1'b0, 32'h0});
    @(posedge CLK); #1;
    RST = 1'b0; dREN = '0; iREN = 2'b11; ramstate = FREE;
    @(negedge CLK);
    chk("rst_idle", {ramREN, iwait}, {1'b0, 2'b11});
    @(posedge CLK); #1;
    ramstate = ACCESS; ramload = 32'h88;
    @(negedge CLK);
    chk("rst_rrptr_grant", {ramREN, ramaddr, iwait, iload}, {1'b1, 32'h40, 2'b10, 64'h88});
    @(posedge CLK); #1;
    iREN = '0; ramstate = FREE;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
